// File: rtl/sdram_apb_arbiter.sv
// Two-requester APB arbiter that serialises access to a single SDRAM APB bridge.
// Define SDRAM_APB_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority with m0 first.
module sdram_apb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_paddr,
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic [2:0]          m0_pprot,
  input  logic                m0_pwrite,
  input  logic [DATA_W-1:0]   m0_pwdata,
  input  logic [DATA_W/8-1:0] m0_pstrb,
  output logic                m0_pready,
  output logic [DATA_W-1:0]   m0_prdata,
  output logic                m0_pslverr,
  input  logic [ADDR_W-1:0]   m1_paddr,
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic [2:0]          m1_pprot,
  input  logic                m1_pwrite,
  input  logic [DATA_W-1:0]   m1_pwdata,
  input  logic [DATA_W/8-1:0] m1_pstrb,
  output logic                m1_pready,
  output logic [DATA_W-1:0]   m1_prdata,
  output logic                m1_pslverr,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0] state_r;
  logic       grant_r;
  logic       last_grant_r;
  logic       any_req_s;
  logic       pick_s;
  logic       resp_en_s;
  logic       unused_penable_s;

  // Requests are qualified by psel alone; penable is not needed to arbitrate.
  assign unused_penable_s = m0_penable ^ m1_penable;

  // Arbitration: pick which requester wins when the bus is idle.
  always_comb begin
    any_req_s = m0_psel | m1_psel;
    pick_s    = 1'b0;
    if (m0_psel && m1_psel) begin
`ifdef SDRAM_APB_ARB_RR_EN
      pick_s = ~last_grant_r;
`else
      pick_s = 1'b0;
`endif
    end else if (m1_psel) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Transfer sequencer and registered master-side bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      out_psel     <= 1'b0;
      out_penable  <= 1'b0;
      out_paddr    <= {ADDR_W{1'b0}};
      out_pprot    <= 3'b000;
      out_pwrite   <= 1'b0;
      out_pwdata   <= {DATA_W{1'b0}};
      out_pstrb    <= {(DATA_W/8){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r     <= SETUP;
            grant_r     <= pick_s;
            out_psel    <= 1'b1;
            out_penable <= 1'b0;
            out_paddr   <= pick_s ? m1_paddr  : m0_paddr;
            out_pprot   <= pick_s ? m1_pprot  : m0_pprot;
            out_pwrite  <= pick_s ? m1_pwrite : m0_pwrite;
            out_pwdata  <= pick_s ? m1_pwdata : m0_pwdata;
            out_pstrb   <= pick_s ? m1_pstrb  : m0_pstrb;
          end
        end
        SETUP: begin
          state_r     <= ACCESS;
          out_penable <= 1'b1;
        end
        ACCESS: begin
          // A requester that dropped psel mid-transfer still sees the bus transfer finish.
          if (out_pready) begin
            state_r      <= IDLE;
            out_psel     <= 1'b0;
            out_penable  <= 1'b0;
            last_grant_r <= grant_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_psel    <= 1'b0;
          out_penable <= 1'b0;
        end
      endcase
    end
  end

  // A transfer killed by reset must not hand back a completion.
  assign resp_en_s  = out_pready & (state_r == ACCESS) & ~reset;
  assign m0_pready  = resp_en_s & ~grant_r;
  assign m1_pready  = resp_en_s &  grant_r;
  assign m0_pslverr = out_pslverr & m0_pready;
  assign m1_pslverr = out_pslverr & m1_pready;
  assign m0_prdata  = out_prdata;
  assign m1_prdata  = out_prdata;

endmodule
